// File: rtl/alu_mc.sv
// Handshaked execute-stage ALU: single-cycle logic/shift/compare ops plus
// iterative shift-add multiply and restoring unsigned divide/remainder.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// BUSY  | one multiply/divide iteration per cycle, counter counts down
// DONE  | out_valid high, Result and flags held until out_ready
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             V,
    output logic             N,
    output logic             Zero
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;
    localparam logic [3:0] OP_REMU = 4'b1100;

    state_t           state;
    logic [SHW-1:0]   cnt;
    logic [3:0]       op;
    logic [WIDTH-1:0] opa, opb, acc;

    logic [WIDTH-1:0] comb_res;
    logic             comb_v, comb_n, comb_z, multi;
    logic [WIDTH-1:0] mul_nx, rem_nx, quo_nx;
    logic [WIDTH:0]   trial, trial_sub;
    logic             ge;

    assign in_ready = (state == IDLE);
    assign multi = (ALUControl == OP_MUL) || (ALUControl == OP_DIVU) || (ALUControl == OP_REMU);

    always_comb begin
        comb_res = '0;
        comb_v   = 1'b0;
        comb_n   = 1'b0;
        comb_z   = 1'b0;
        case (ALUControl)
            OP_ADD:  comb_res = A + B;
            OP_SUB:  comb_res = A - B;
            OP_AND:  comb_res = A & B;
            OP_OR:   comb_res = A | B;
            OP_XOR:  comb_res = A ^ B;
            OP_SLL:  comb_res = A << B[SHW-1:0];
            OP_SRL:  comb_res = A >> B[SHW-1:0];
            OP_SLT:  comb_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SRA:  comb_res = $signed(A) >>> B[SHW-1:0];
            OP_SLTU: comb_res = {{(WIDTH-1){1'b0}}, (A < B)};
            default: comb_res = '0;
        endcase
        if (ALUControl == OP_ADD || ALUControl == OP_SUB) begin
            comb_n = comb_res[WIDTH-1];
            comb_z = (comb_res == '0);
            if (ALUControl == OP_ADD)
                comb_v = (A[WIDTH-1] == B[WIDTH-1]) && (comb_res[WIDTH-1] != A[WIDTH-1]);
            else
                comb_v = (A[WIDTH-1] != B[WIDTH-1]) && (comb_res[WIDTH-1] != A[WIDTH-1]);
        end
    end

    // Multiply: opa shifts left, opb shifts right. Divide: opa holds the
    // dividend shifting out while quotient bits shift in; acc is the remainder.
    always_comb begin
        mul_nx    = acc + (opb[0] ? opa : '0);
        trial     = {acc, opa[WIDTH-1]};
        trial_sub = trial - {1'b0, opb};
        ge        = (trial >= {1'b0, opb});
        rem_nx    = ge ? trial_sub[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nx    = {opa[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op        <= '0;
            opa       <= '0;
            opb       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            Result    <= '0;
            V         <= 1'b0;
            N         <= 1'b0;
            Zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op  <= ALUControl;
                    opa <= A;
                    opb <= B;
                    acc <= '0;
                    if (multi) begin
                        cnt   <= SHW'(WIDTH - 1);
                        state <= BUSY;
                    end else begin
                        Result    <= comb_res;
                        V         <= comb_v;
                        N         <= comb_n;
                        Zero      <= comb_z;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                BUSY: begin
                    if (op == OP_MUL) begin
                        acc <= mul_nx;
                        opa <= opa << 1;
                        opb <= opb >> 1;
                    end else begin
                        acc <= rem_nx;
                        opa <= quo_nx;
                    end
                    if (cnt == '0) begin
                        Result    <= (op == OP_MUL) ? mul_nx : (op == OP_DIVU) ? quo_nx : rem_nx;
                        V         <= 1'b0;
                        N         <= 1'b0;
                        Zero      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - SHW'(1);
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: randomized ops against an arithmetic
// reference model, plus directed cases, reset abort and an 8-bit divide.
module tb_alu_mc;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] A, B, Result;
    logic [3:0] ALUControl;
    logic V, N, Zero;

    logic in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0] A8, B8, Result8;
    logic [3:0] op8;
    logic V8, N8, Z8;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_res;
    logic exp_v, exp_n, exp_z;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUControl(ALUControl), .out_valid(out_valid),
        .out_ready(out_ready), .Result(Result), .V(V), .N(N), .Zero(Zero)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(A8), .B(B8), .ALUControl(op8), .out_valid(out_valid8),
        .out_ready(out_ready8), .Result(Result8), .V(V8), .N(N8), .Zero(Z8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Returns {V, N, Zero, Result} computed with plain arithmetic.
    function automatic logic [W+2:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic v, n, z;
        logic [63:0] p;
        longint s;
        int sh;
        r = '0; v = 1'b0; n = 1'b0; z = 1'b0;
        sh = int'(b % W);
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << sh;
            4'd6:  r = a >> sh;
            4'd7:  r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd8:  r = $signed(a) >>> sh;
            4'd9:  r = (a < b) ? 1 : 0;
            4'd10: begin p = 64'(a) * 64'(b); r = p[W-1:0]; end
            4'd11: r = (b == 0) ? '1 : a / b;
            4'd12: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        if (op <= 4'd1) begin
            n = r[W-1];
            z = (r == 0);
            if (op == 4'd0) s = longint'($signed(a)) + longint'($signed(b));
            else            s = longint'($signed(a)) - longint'($signed(b));
            v = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
        end
        return {v, n, z, r};
    endfunction

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            check("result", Result, exp_res);
            check("flag_v", V, exp_v);
            check("flag_n", N, exp_n);
            check("flag_zero", Zero, exp_z);
            check("in_ready_done", in_ready, 1'b0);
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input bit toggle, input bit early);
        int lat, exp_lat;
        logic [W+2:0] m;
        logic [W-1:0] held;
        m = model(op, a, b);
        @(negedge clk);
        A = a; B = b; ALUControl = op; in_valid = 1'b1; out_ready = 1'b0;
        {exp_v, exp_n, exp_z, exp_res} = m;
        exp_lat = (op >= 4'd10 && op <= 4'd12) ? W + 1 : 1;
        check("in_ready_idle", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (early) out_ready = 1'b1;
        lat = 1;
        while (!out_valid && lat < 100) begin
            check("in_ready_busy", in_ready, 1'b0);
            if (toggle) begin A = $urandom; B = $urandom; ALUControl = 4'($urandom); end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        held = Result;
        if (!early) begin
            repeat (hold) begin
                @(posedge clk); #1;
                check("hold_valid", out_valid, 1'b1);
                check("hold_stable", Result, held);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_hs_valid", out_valid, 1'b0);
        check("post_hs_ready", in_ready, 1'b1);
    endtask

    task automatic pin(input string name, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r, input logic v, input logic n, input logic z,
                       input int hold, input bit toggle);
        check(name, model(op, a, b), {v, n, z, r});
        run_op(op, a, b, hold, toggle, 1'b0);
    endtask

    initial begin
        int lat;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; ALUControl = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; A8 = '0; B8 = '0; op8 = '0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_result", Result, '0);
        check("rst_flags", {V, N, Zero}, 3'b000);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        pin("pin_add_ovf", 4'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 1, 0, 0, 0);
        pin("pin_sub_zero", 4'd1, 32'h1234, 32'h1234, 32'h0, 0, 0, 1, 0, 0);
        pin("pin_slt", 4'd7, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0, 0, 0, 0);
        pin("pin_sltu", 4'd9, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 0, 0, 0, 0);
        pin("pin_sra", 4'd8, 32'h80000000, 32'h24, 32'hF8000000, 0, 0, 0, 0, 0);
        pin("pin_srl", 4'd6, 32'h80000000, 32'h24, 32'h08000000, 0, 0, 0, 0, 0);
        pin("pin_sll", 4'd5, 32'h80000000, 32'h24, 32'h0, 0, 0, 0, 0, 0);
        pin("pin_mul", 4'd10, 32'h00010003, 32'h00020005, 32'h000B000F, 0, 0, 0, 5, 1);
        pin("pin_divu", 4'd11, 32'd100, 32'd7, 32'd14, 0, 0, 0, 0, 1);
        pin("pin_remu", 4'd12, 32'd100, 32'd7, 32'd2, 0, 0, 0, 0, 0);
        pin("pin_divu0", 4'd11, 32'h12345678, 32'h0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
        pin("pin_remu0", 4'd12, 32'h55, 32'h0, 32'h55, 0, 0, 0, 0, 0);
        pin("pin_undef", 4'd13, 32'h5, 32'h7, 32'h0, 0, 0, 0, 5, 0);

        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
            run_op(4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 2),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a multiply.
        @(negedge clk);
        A = 32'h1234; B = 32'h5678; ALUControl = 4'd10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_result", Result, '0);
        check("abort_flags", {V, N, Zero}, 3'b000);
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_hold_valid", out_valid, 1'b0);
        end
        @(negedge clk);
        reset = 1'b0;
        A = 32'd5; B = 32'd3; ALUControl = 4'd1; in_valid = 1'b1;
        {exp_v, exp_n, exp_z, exp_res} = model(4'd1, 32'd5, 32'd3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("post_reset_accept", out_valid, 1'b1);
        check("post_reset_result", Result, 32'd2);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // 8-bit build: DIVU 0xFF / 0x10.
        @(negedge clk);
        A8 = 8'hFF; B8 = 8'h10; op8 = 4'd11; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w8_latency", lat, 9);
        check("w8_divu", Result8, 8'h0F);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        check("w8_post_hs", in_ready8, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, handshaked ALU that extends the single-cycle RV32 ALU with a configurable datapath width, the full RV32I shift/compare set, and iterative multi-cycle multiply and unsigned divide/remainder. It sits between operand fetch and writeback in the execute stage. Operands are accepted on a valid/ready input handshake, and results plus flags are held on a valid/ready output handshake until consumed.

## Interface
- WIDTH, 32: datapath width. Power of two, at least 8.
- SHW, $clog2(WIDTH): shift-amount width (derived; do not override).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and op are presented.
- in_ready  out  1  block can accept; equals (state == IDLE).
- A  in  WIDTH  operand A; signed where the op requires.
- B  in  WIDTH  operand B; signed where the op requires.
- ALUControl  in  4  operation select.
- out_valid  out  1  Result and flags are valid.
- out_ready  in  1  consumer takes the result.
- Result  out  WIDTH  registered result.
- V, N, Zero  out  1 each  registered flags.

## Operation
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SLT (signed), 1000 SRA, 1001 SLTU.
  - 1010 MUL (low WIDTH bits of A*B), 1011 DIVU, 1100 REMU.
  - 1101–1111 are undefined: Result = 0, all flags 0, single-cycle.
- Shifts use B[SHW-1:0] only. Upper bits of B are ignored.
- SLT/SLTU return 1 or 0, zero-extended to WIDTH.
- SLT compares signed directly. It is not the sign of A-B, so there is no overflow error.
- Flags apply only to ADD and SUB. All other ops drive V = N = Zero = 0.
  - N = Result[WIDTH-1].
  - Zero = (Result == 0).
  - ADD: V = (A[MSB] == B[MSB]) && (Result[MSB] != A[MSB]).
  - SUB: V = (A[MSB] != B[MSB]) && (Result[MSB] != A[MSB]).
- MUL uses an iterative shift-add over WIDTH steps, one bit of B per cycle. It keeps only a WIDTH-bit accumulator.
- DIVU/REMU use a restoring divider over WIDTH steps, one quotient bit per cycle.
- Divide by zero: DIVU gives all ones and REMU gives A. The full WIDTH iterations are still spent, so latency is constant.
- Operands and op are captured at acceptance. Input changes after acceptance have no effect.
- State machine:
  - IDLE: in_ready = 1. On in_valid, capture A, B and op.
    - Single-cycle op: compute and go to DONE.
    - MUL/DIVU/REMU: load the iteration counter to WIDTH-1 and go to BUSY.
  - BUSY: one iteration per cycle, decrementing the counter. Leave when the counter is 0: write Result and go to DONE.
  - DONE: out_valid = 1. Result and flags are held stable. When out_ready = 1, go to IDLE.
- in_ready is 0 in BUSY and DONE. No new operation is accepted until the result is consumed.

## Timing
- Reset (asynchronous, active-high):
  - State goes to IDLE and the counter to 0.
  - out_valid = 0, Result = 0, V = N = Zero = 0.
  - in_ready = 1 while reset is asserted and afterwards.
- Reset asserted during BUSY or DONE aborts the operation. No out_valid pulse follows, and the in-flight result is discarded.
- Single-cycle op accepted at edge k: out_valid = 1 from edge k+1.
- MUL/DIV accepted at edge k: out_valid = 1 from edge k+WIDTH+1 (33 cycles for WIDTH = 32).
- Output handshake completes on the edge where out_valid && out_ready. The state is IDLE after that edge.
- Peak throughput is one single-cycle op per 2 cycles, because there is no overlap of DONE and IDLE.
- out_ready high in advance is permitted. DONE still lasts at least one cycle.
- Flags change only on the edge that writes Result.

## Test plan
- ADD overflow: WIDTH = 32, A = 0x7FFFFFFF, B = 1.
  - Expect Result = 0x80000000, V = 1, N = 1, Zero = 0.
  - out_valid rises 1 cycle after accept.
- SUB zero and compare: A = B = 0x00001234 with op SUB gives Result = 0, Zero = 1, N = 0, V = 0.
  - SLT with A = 0xFFFFFFFF, B = 1 gives 1.
  - SLTU with the same operands gives 0.
- Shifts: A = 0x80000000, B = 0x00000024 (shift amount 4).
  - SRA gives 0xF8000000, SRL gives 0x08000000, SLL gives 0.
- MUL and latency: A = 0x00010003, B = 0x00020005 gives Result = 0x000B000F.
  - out_valid exactly 33 cycles after accept.
  - in_ready = 0 throughout.
  - A/B toggled during BUSY do not change the result.
- Divide: DIVU 100/7 gives 14; REMU 100/7 gives 2.
  - DIVU x/0 gives 0xFFFFFFFF; REMU 0x55/0 gives 0x55.
  - WIDTH = 8 build: DIVU 0xFF/0x10 gives 0x0F with latency 9.
- Handshake and reset:
  - Hold out_ready = 0 for 5 cycles in DONE: Result stays stable and in_ready stays 0.
  - Assert reset mid-BUSY: out_valid stays 0, all outputs read 0, and a new op is accepted on the first edge after release.
